// File: rtl/dp_types_pkg.sv
// Shared datapath/cache types: instruction-cache geometry, address breakdown, frame layout and FSM states.
package dp_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NSETS  = 16;
  localparam int unsigned IDX_W  = $clog2(NSETS);
  localparam int unsigned TAG_W  = WORD_W - IDX_W - 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bytoff;
  } icachef_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// Direct-mapped frame storage: one async read port, one sync write port, valid bits cleared on reset.
module icache_frame_array
  import dp_types_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] ridx,
  output icache_frame_t    rframe,
  input  logic             wen,
  input  logic [IDX_W-1:0] widx,
  input  icache_frame_t    wframe
);

  icache_frame_t frames [NSETS];

  // Only valid bits are reset; tag and data are don't-care until written.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < int'(NSETS); i++) begin
        frames[i].valid <= 1'b0;
      end
    end else if (wen) begin
      frames[widx] <= wframe;
    end
  end

  assign rframe = frames[ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: same-cycle hit lookup, single-word refill from memory control, perf counters.
module icache
  import dp_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] hit_count,
  output logic [WORD_W-1:0] miss_count
);

  icache_state_t     state, next_state;
  logic [WORD_W-1:0] maddr, maddr_next;
  icachef_t          req, mreq;
  icache_frame_t     rframe, wframe;
  logic              fill;
  logic              wen;

  assign req  = icachef_t'(imemaddr);
  assign mreq = icachef_t'(maddr);

  icache_frame_array u_frames (
    .CLK    (CLK),
    .nRST   (nRST),
    .ridx   (req.idx),
    .rframe (rframe),
    .wen    (wen),
    .widx   (mreq.idx),
    .wframe (wframe)
  );

  // A reset in the fill cycle must not leave a valid frame behind.
  assign wen    = fill & nRST;
  assign wframe = '{valid: 1'b1, tag: mreq.tag, data: iload};

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      maddr      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= next_state;
      maddr <= maddr_next;
      if (ihit && (hit_count != '1)) begin
        hit_count <= hit_count + WORD_W'(1);
      end
      if (fill && (miss_count != '1)) begin
        miss_count <= miss_count + WORD_W'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    maddr_next = maddr;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    fill       = 1'b0;
    unique case (state)
      IDLE: begin
        if (imemREN) begin
          if (rframe.valid && (rframe.tag == req.tag)) begin
            ihit     = 1'b1;
            imemload = rframe.data;
          end else begin
            maddr_next = imemaddr;
            next_state = MISS;
          end
        end
      end
      MISS: begin
        iREN  = 1'b1;
        iaddr = maddr;
        if (!iwait) begin
          fill       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: per-cycle vector table fed through an expected-output scoreboard queue.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        nrst;
    logic        ren;
    logic [31:0] addr;
    logic        iwait;
    logic [31:0] iload;
    logic        ihit;
    logic [31:0] load;
    logic        iren;
    logic [31:0] iaddr;
  } vec_t;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  vec_t tv [$];
  vec_t exp_q [$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   next_v = 0;
  int   exp_hits = 0;
  int   exp_miss = 0;

  function automatic vec_t v(logic nrst, logic ren, logic [31:0] addr, logic iw, logic [31:0] ild,
                             logic eh, logic [31:0] el, logic er, logic [31:0] ea);
    vec_t r;
    r.nrst = nrst; r.ren = ren; r.addr = addr; r.iwait = iw; r.iload = ild;
    r.ihit = eh; r.load = el; r.iren = er; r.iaddr = ea;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_counters(string tag);
    check({tag, " hit_count"}, hit_count, 32'(exp_hits));
    check({tag, " miss_count"}, miss_count, 32'(exp_miss));
  endtask

  // Apply all queued vectors not yet run; compare outputs at the falling edge.
  task automatic run_pending();
    vec_t e;
    while (next_v < tv.size()) begin
      nRST     = tv[next_v].nrst;
      imemREN  = tv[next_v].ren;
      imemaddr = tv[next_v].addr;
      iwait    = tv[next_v].iwait;
      iload    = tv[next_v].iload;
      exp_q.push_back(tv[next_v]);
      @(negedge CLK);
      e = exp_q.pop_front();
      check($sformatf("v%0d ihit", next_v), 32'(ihit), 32'(e.ihit));
      check($sformatf("v%0d imemload", next_v), imemload, e.load);
      check($sformatf("v%0d iREN", next_v), 32'(iREN), 32'(e.iren));
      check($sformatf("v%0d iaddr", next_v), iaddr, e.iaddr);
      @(posedge CLK);
      if (!e.nrst) begin
        exp_hits = 0;
        exp_miss = 0;
      end else begin
        if (e.ihit) exp_hits++;
        if (e.iren && !e.iwait) exp_miss++;
      end
      #1;
      next_v++;
    end
  endtask

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = JUNK;
    repeat (2) @(posedge CLK);
    #1;
    check("reset ihit", 32'(ihit), 32'h0);
    check("reset iREN", 32'(iREN), 32'h0);
    check("reset iaddr", iaddr, 32'h0);
    check("reset imemload", imemload, 32'h0);
    chk_counters("reset");

    // No request for 10 cycles
    repeat (10) tv.push_back(v(1, 0, 32'h40, 1, JUNK, 0, 0, 0, 0));
    run_pending();
    chk_counters("idle");

    // Cold miss with three wait cycles
    tv.push_back(v(1, 1, 32'h40, 1, JUNK, 0, 0, 0, 0));
    repeat (3) tv.push_back(v(1, 1, 32'h40, 1, JUNK, 0, 0, 1, 32'h40));
    tv.push_back(v(1, 1, 32'h40, 0, 32'h2001_0005, 0, 0, 1, 32'h40));
    tv.push_back(v(1, 1, 32'h40, 1, JUNK, 1, 32'h2001_0005, 0, 0));
    run_pending();
    chk_counters("cold miss");

    // Repeated hits
    repeat (5) tv.push_back(v(1, 1, 32'h40, 1, JUNK, 1, 32'h2001_0005, 0, 0));
    run_pending();
    chk_counters("hits");

    // Conflict on index 0: 0x440 evicts 0x40, then 0x40 misses again
    tv.push_back(v(1, 1, 32'h440, 1, JUNK, 0, 0, 0, 0));
    tv.push_back(v(1, 1, 32'h440, 1, JUNK, 0, 0, 1, 32'h440));
    tv.push_back(v(1, 1, 32'h440, 0, 32'h1111_1111, 0, 0, 1, 32'h440));
    tv.push_back(v(1, 1, 32'h440, 1, JUNK, 1, 32'h1111_1111, 0, 0));
    tv.push_back(v(1, 1, 32'h40, 1, JUNK, 0, 0, 0, 0));
    tv.push_back(v(1, 1, 32'h40, 0, 32'h2001_0005, 0, 0, 1, 32'h40));
    tv.push_back(v(1, 1, 32'h40, 1, JUNK, 1, 32'h2001_0005, 0, 0));
    run_pending();
    chk_counters("conflict");

    // Address changes mid-miss: fill completes for 0x80, then 0x84 misses
    tv.push_back(v(1, 1, 32'h80, 1, JUNK, 0, 0, 0, 0));
    tv.push_back(v(1, 1, 32'h84, 1, JUNK, 0, 0, 1, 32'h80));
    tv.push_back(v(1, 1, 32'h84, 0, 32'h8080_8080, 0, 0, 1, 32'h80));
    tv.push_back(v(1, 1, 32'h84, 1, JUNK, 0, 0, 0, 0));
    tv.push_back(v(1, 1, 32'h84, 0, 32'h8484_8484, 0, 0, 1, 32'h84));
    tv.push_back(v(1, 1, 32'h84, 1, JUNK, 1, 32'h8484_8484, 0, 0));
    tv.push_back(v(1, 1, 32'h80, 1, JUNK, 1, 32'h8080_8080, 0, 0));
    run_pending();
    chk_counters("mid-miss");

    // Reset in the fill cycle: no frame written, everything invalid afterwards
    tv.push_back(v(1, 1, 32'h100, 1, JUNK, 0, 0, 0, 0));
    tv.push_back(v(0, 1, 32'h100, 0, 32'h5555_5555, 0, 0, 1, 32'h100));
    run_pending();
    chk_counters("reset mid-miss");
    tv.push_back(v(1, 1, 32'h100, 1, JUNK, 0, 0, 0, 0));
    tv.push_back(v(1, 1, 32'h100, 0, 32'h0010_0100, 0, 0, 1, 32'h100));
    tv.push_back(v(1, 1, 32'h100, 1, JUNK, 1, 32'h0010_0100, 0, 0));
    tv.push_back(v(1, 1, 32'h84, 1, JUNK, 0, 0, 0, 0));
    tv.push_back(v(1, 0, 32'h84, 0, 32'h8484_0000, 0, 0, 1, 32'h84));
    tv.push_back(v(1, 0, 32'h84, 1, JUNK, 0, 0, 0, 0));
    tv.push_back(v(1, 1, 32'h84, 1, JUNK, 1, 32'h8484_0000, 0, 0));
    run_pending();
    chk_counters("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
